// File: rtl/lmem_responder_if.sv
// LSU memory request/response bus between the LSU switch (master) and a local memory (slave).
interface VX_lsu_mem_if #(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned WORD_SIZE   = 4,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned FLAGS_WIDTH = 4,
    parameter int unsigned TAG_WIDTH   = 8
);
    logic                                       req_valid;
    logic                                       req_ready;
    logic [NUM_LANES-1:0]                       req_mask;
    logic                                       req_rw;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]       req_addr;
    logic [NUM_LANES-1:0][WORD_SIZE*8-1:0]      req_data;
    logic [NUM_LANES-1:0][WORD_SIZE-1:0]        req_byteen;
    logic [NUM_LANES-1:0][FLAGS_WIDTH-1:0]      req_flags;
    logic [TAG_WIDTH-1:0]                       req_tag;

    logic                                       rsp_valid;
    logic                                       rsp_ready;
    logic [NUM_LANES-1:0]                       rsp_mask;
    logic [NUM_LANES-1:0][WORD_SIZE*8-1:0]      rsp_data;
    logic [TAG_WIDTH-1:0]                       rsp_tag;

    modport master (
        output req_valid, req_mask, req_rw, req_addr, req_data, req_byteen, req_flags, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_mask, rsp_data, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_mask, req_rw, req_addr, req_data, req_byteen, req_flags, req_tag,
        output req_ready,
        output rsp_valid, rsp_mask, rsp_data, rsp_tag,
        input  rsp_ready
    );
endinterface

// File: rtl/lmem_responder.sv
// Flop-based local scratchpad servicing one LSU request at a time, lane by lane.
// Define LMEM_WRITE_ACK_EN to make writes return a response like reads do.
module lmem_responder #(
    parameter int unsigned SIZE          = 4096,
    parameter int unsigned RSP_OUT_BUF   = 0,
    parameter int unsigned NUM_LSU_LANES = 4,
    parameter int unsigned LSU_WORD_SIZE = 4,
    parameter int unsigned LSU_TAG_WIDTH = 8
) (
    input logic          clk,
    input logic          reset,
    VX_lsu_mem_if.slave  lsu_in_if
);
    localparam int unsigned DEPTH        = SIZE / LSU_WORD_SIZE;
    localparam int unsigned ROW_W        = $clog2(DEPTH);
    localparam int unsigned WORD_W       = LSU_WORD_SIZE * 8;
    localparam int unsigned LANE_W       = (NUM_LSU_LANES > 1) ? $clog2(NUM_LSU_LANES) : 1;
    localparam int unsigned OUT_BUF_SIZE = RSP_OUT_BUF & 7;
`ifdef LMEM_WRITE_ACK_EN
    localparam bit WRITE_ACK = 1'b1;
`else
    localparam bit WRITE_ACK = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SERVE, S_RESP} state_e;

    state_e                                 state_q, state_d;
    logic                                   req_ready_q, req_ready_d;
    logic                                   rsp_valid_q, rsp_valid_d;
    logic                                   rw_q, rw_d;
    logic [NUM_LSU_LANES-1:0]               mask_q, mask_d;
    logic [NUM_LSU_LANES-1:0]               pending_q, pending_d;
    logic [NUM_LSU_LANES-1:0][ROW_W-1:0]    row_q, row_d;
    logic [NUM_LSU_LANES-1:0][WORD_W-1:0]   wdata_q, wdata_d;
    logic [NUM_LSU_LANES-1:0][LSU_WORD_SIZE-1:0] byteen_q, byteen_d;
    logic [LSU_TAG_WIDTH-1:0]               tag_q, tag_d;
    logic [NUM_LSU_LANES-1:0][WORD_W-1:0]   rdata_q, rdata_d;

    logic [WORD_W-1:0]        mem_q [DEPTH];
    logic [LANE_W-1:0]        lane;
    logic [NUM_LSU_LANES-1:0] pending_clr;
    logic                     mem_we;
    logic                     resp_done;
    logic                     unused_in;

    assign unused_in = ^{lsu_in_if.req_flags, lsu_in_if.req_addr};

    // Lowest pending lane goes first, so the highest lane wins a same-row write.
    always_comb begin
        lane = '0;
        for (int unsigned i = NUM_LSU_LANES; i > 0; i--) begin
            if (pending_q[i-1]) lane = LANE_W'(i - 1);
        end
    end

    assign pending_clr = pending_q & ~(NUM_LSU_LANES'(1) << lane);

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        mask_d    = mask_q;
        pending_d = pending_q;
        row_d     = row_q;
        wdata_d   = wdata_q;
        byteen_d  = byteen_q;
        tag_d     = tag_q;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lsu_in_if.req_valid && req_ready_q) begin
                    rw_d      = lsu_in_if.req_rw;
                    mask_d    = lsu_in_if.req_mask;
                    pending_d = lsu_in_if.req_mask;
                    wdata_d   = lsu_in_if.req_data;
                    byteen_d  = lsu_in_if.req_byteen;
                    tag_d     = lsu_in_if.req_tag;
                    rdata_d   = '0;
                    for (int unsigned i = 0; i < NUM_LSU_LANES; i++) begin
                        row_d[i] = lsu_in_if.req_addr[i][ROW_W-1:0];
                    end
                    if (lsu_in_if.req_mask != '0)
                        state_d = S_SERVE;
                    else if (!lsu_in_if.req_rw || WRITE_ACK)
                        state_d = S_RESP;
                end
            end
            S_SERVE: begin
                pending_d = pending_clr;
                if (rw_q) mem_we = 1'b1;
                else      rdata_d[lane] = mem_q[row_q[lane]];
                if (pending_clr == '0)
                    state_d = (!rw_q || WRITE_ACK) ? S_RESP : S_IDLE;
            end
            S_RESP: begin
                if (resp_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rw_q        <= 1'b0;
            mask_q      <= '0;
            pending_q   <= '0;
            row_q       <= '0;
            wdata_q     <= '0;
            byteen_q    <= '0;
            tag_q       <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rw_q        <= rw_d;
            mask_q      <= mask_d;
            pending_q   <= pending_d;
            row_q       <= row_d;
            wdata_q     <= wdata_d;
            byteen_q    <= byteen_d;
            tag_q       <= tag_d;
            rdata_q     <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            for (int unsigned b = 0; b < LSU_WORD_SIZE; b++) begin
                if (byteen_q[lane][b])
                    mem_q[row_q[lane]][b*8 +: 8] <= wdata_q[lane][b*8 +: 8];
            end
        end
    end

    assign lsu_in_if.req_ready = req_ready_q;

    if (OUT_BUF_SIZE == 0) begin : g_direct
        assign resp_done          = lsu_in_if.rsp_ready;
        assign lsu_in_if.rsp_valid = rsp_valid_q;
        assign lsu_in_if.rsp_mask  = mask_q;
        assign lsu_in_if.rsp_data  = rdata_q;
        assign lsu_in_if.rsp_tag   = tag_q;
    end else begin : g_buf
        logic                                 ob_valid_q, ob_valid_d;
        logic [NUM_LSU_LANES-1:0]             ob_mask_q, ob_mask_d;
        logic [NUM_LSU_LANES-1:0][WORD_W-1:0] ob_data_q, ob_data_d;
        logic [LSU_TAG_WIDTH-1:0]             ob_tag_q, ob_tag_d;

        // RESP hands its payload to the output register as soon as it is free or draining.
        assign resp_done = !ob_valid_q || lsu_in_if.rsp_ready;

        always_comb begin
            ob_valid_d = ob_valid_q;
            ob_mask_d  = ob_mask_q;
            ob_data_d  = ob_data_q;
            ob_tag_d   = ob_tag_q;
            if (rsp_valid_q && resp_done) begin
                ob_valid_d = 1'b1;
                ob_mask_d  = mask_q;
                ob_data_d  = rdata_q;
                ob_tag_d   = tag_q;
            end else if (lsu_in_if.rsp_ready) begin
                ob_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                ob_valid_q <= 1'b0;
                ob_mask_q  <= '0;
                ob_data_q  <= '0;
                ob_tag_q   <= '0;
            end else begin
                ob_valid_q <= ob_valid_d;
                ob_mask_q  <= ob_mask_d;
                ob_data_q  <= ob_data_d;
                ob_tag_q   <= ob_tag_d;
            end
        end

        assign lsu_in_if.rsp_valid = ob_valid_q;
        assign lsu_in_if.rsp_mask  = ob_mask_q;
        assign lsu_in_if.rsp_data  = ob_data_q;
        assign lsu_in_if.rsp_tag   = ob_tag_q;
    end
endmodule
